booth_multiplier: RTL and testbench



---
 rtl/booth_multiplier_pkg.sv | 13 +
 rtl/booth_multiplier_step.sv | 36 +++
 rtl/booth_multiplier.sv | 110 +++++++++++
 tb/tb_booth_multiplier.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/booth_multiplier_pkg.sv
// Shared constants and state encoding for the radix-2 Booth multiplier.
package booth_multiplier_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/booth_multiplier_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of the {A, Q, Q_-1} concatenation.
module booth_multiplier_step
  import booth_multiplier_pkg::*;
(
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_m1_next
);

  logic [WIDTH:0]     sum;
  logic [2*WIDTH+1:0] cat;
  logic [2*WIDTH+1:0] shifted;

  always_comb begin
    sum = a;
    case ({q[0], q_m1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
  end

  // A carries one guard bit, so the sign is always sum[WIDTH].
  assign cat     = {sum, q, q_m1};
  assign shifted = {cat[2*WIDTH+1], cat[2*WIDTH+1:1]};

  assign a_next    = shifted[2*WIDTH+1:WIDTH+1];
  assign q_next    = shifted[WIDTH:1];
  assign q_m1_next = shifted[0];

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed WIDTH x WIDTH Booth multiplier: one bit pair per clock,
// result published on hi/lo together with the finished level.
//
// state | meaning
// IDLE  | no result yet since reset; waiting for mult_start
// RUN   | stepping; count_q down-counts remaining Booth steps
// DONE  | hi/lo valid, finished high; mult_start restarts
module booth_multiplier
  import booth_multiplier_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             mult_start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             finished,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mult_state_e      state_q;
  mult_state_e      state_d;

  logic [WIDTH:0]   acc_q;
  logic [WIDTH:0]   m_q;
  logic [WIDTH-1:0] q_q;
  logic             q_m1_q;
  logic [CNT_W-1:0] count_q;

  logic [WIDTH:0]   acc_step;
  logic [WIDTH-1:0] q_step;
  logic             q_m1_step;

  logic             count_tc;
  logic             load;
  logic             step;
  logic             capture;

  assign count_tc = (count_q == '0);

  booth_multiplier_step u_step (
    .a         (acc_q),
    .q         (q_q),
    .q_m1      (q_m1_q),
    .m         (m_q),
    .a_next    (acc_step),
    .q_next    (q_step),
    .q_m1_next (q_m1_step)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mult_start) state_d = RUN;
      RUN:     if (count_tc)   state_d = DONE;
      DONE:    if (mult_start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Once the counter hits zero the next edge only publishes the result.
  always_comb begin
    load    = 1'b0;
    step    = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE, DONE: load = mult_start;
      RUN: begin
        step    = !count_tc;
        capture = count_tc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q    <= '0;
      m_q      <= '0;
      q_q      <= '0;
      q_m1_q   <= 1'b0;
      count_q  <= '0;
      finished <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (load) begin
      acc_q    <= '0;
      m_q      <= {multiplicand[WIDTH-1], multiplicand};
      q_q      <= multiplier;
      q_m1_q   <= 1'b0;
      count_q  <= CNT_W'(WIDTH);
      finished <= 1'b0;
    end else if (step) begin
      acc_q   <= acc_step;
      q_q     <= q_step;
      q_m1_q  <= q_m1_step;
      count_q <= count_q - 1'b1;
    end else if (capture) begin
      hi       <= acc_q[WIDTH-1:0];
      lo       <= q_q;
      finished <= 1'b1;
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench for booth_multiplier: expected products are queued at
// start and compared when finished rises.
module tb_booth_multiplier;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mult_start = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic        finished;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    bit          use_ref;
  } vec_t;

  vec_t vecs[9] = '{
    '{32'd5,               32'd3,               64'h0000_0000_0000_000F, 1'b0},
    '{32'd3,               32'hFFFF_FFFE,       64'hFFFF_FFFF_FFFF_FFFA, 1'b0},
    '{32'hFFFF_FFF8,       32'hFFFF_FFF9,       64'h0000_0000_0000_0038, 1'b0},
    '{32'd1000000003,      32'd2000000002,      64'h1BC1_6D69_2B9E_5006, 1'b0},
    '{-32'sd1000000002,    -32'sd1000000006,    64'h0DE0_B6B5_843A_500C, 1'b0},
    '{-32'sd1500000001,    32'd2000000007,      64'h0,                   1'b1},
    '{32'd1500000009,      -32'sd1500000004,    64'h0,                   1'b1},
    '{32'h8000_0000,       32'h8000_0000,       64'h4000_0000_0000_0000, 1'b0},
    '{32'h7FFF_FFFF,       32'h8000_0000,       64'h0,                   1'b1}
  };

  booth_multiplier dut (
    .clock        (clock),
    .reset        (reset),
    .mult_start   (mult_start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .finished     (finished),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    @(negedge clock);
    mult_start   = 1'b1;
    multiplicand = a;
    multiplier   = b;
    exp_q.push_back(exp);
    @(posedge clock);
    #1;
    mult_start = 1'b0;
    check("fin_low_after_start", 64'(finished), 64'd0);
  endtask

  // Called #1 after the start edge; counts edges until finished rises.
  task automatic wait_done(input string tag);
    int          edges;
    int          changes;
    logic [63:0] prev;
    logic [63:0] exp;
    edges   = 0;
    changes = 0;
    prev    = {hi, lo};
    while (!finished && edges < 40) begin
      @(posedge clock);
      #1;
      edges++;
      if (!finished && {hi, lo} !== prev) changes++;
    end
    check({tag, "_latency"}, 64'(edges), 64'd33);
    check({tag, "_hold"}, 64'(changes), 64'd0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    check({tag, "_product"}, {hi, lo}, exp);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (2) @(posedge clock);
    #1;
    check("reset_fin", 64'(finished), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b,
               vecs[i].use_ref ? ref_mul(vecs[i].a, vecs[i].b) : vecs[i].exp);
      wait_done($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      start_op(ra, rb, ref_mul(ra, rb));
      wait_done($sformatf("rand%0d", i));
    end

    // Start pulse with different operands mid-run must be ignored.
    start_op(32'd12345, 32'hFFFF_FF00, ref_mul(32'd12345, 32'hFFFF_FF00));
    fork
      begin
        repeat (5) @(negedge clock);
        mult_start   = 1'b1;
        multiplicand = 32'd999;
        multiplier   = 32'd777;
        @(negedge clock);
        mult_start = 1'b0;
      end
    join_none
    wait_done("ignore_pulse");

    // Abort with reset around cycle 10, then a clean operation.
    start_op(32'd77, 32'd88, ref_mul(32'd77, 32'd88));
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort_fin", 64'(finished), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    void'(exp_q.pop_back());
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("idle_after_reset_fin", 64'(finished), 64'd0);
    start_op(32'hFFFF_FFFD, 32'd41, ref_mul(32'hFFFF_FFFD, 32'd41));
    wait_done("after_reset");
    start_op(32'd6, 32'd7, 64'd42);
    wait_done("back_to_back");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
